// File: rtl/branch_rs_pkg.sv
// Shared definitions for the branch reservation station: order codes,
// default tag width, CDB bundle widths and the ROB relative-age helper.
package branch_rs_pkg;

    localparam int ORDER_W   = 6;
    localparam int ROB_W_DEF = 4;
    localparam int CDB_TAG_W = ROB_W_DEF;
    localparam int CDB_VAL_W = 32;

    localparam logic [ORDER_W-1:0] ORD_JALR = 6'd12;
    localparam logic [ORDER_W-1:0] ORD_JAL  = 6'd30;
    localparam logic [ORDER_W-1:0] ORD_BEQ  = 6'd31;
    localparam logic [ORDER_W-1:0] ORD_BNE  = 6'd32;
    localparam logic [ORDER_W-1:0] ORD_BLT  = 6'd33;
    localparam logic [ORDER_W-1:0] ORD_BGE  = 6'd34;
    localparam logic [ORDER_W-1:0] ORD_BLTU = 6'd35;
    localparam logic [ORDER_W-1:0] ORD_BGEU = 6'd36;

endpackage

// File: rtl/branch_rs_select.sv
// Oldest-ready picker: a binary min tree over (rob - head) mod 2^ROB_W.
module branch_rs_select
    import branch_rs_pkg::*;
#(
    parameter int RS_SIZE = 4,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int IDX_W   = 2
) (
    input  logic [RS_SIZE-1:0]       i_ready,
    input  logic [RS_SIZE*ROB_W-1:0] i_rob,
    input  logic [ROB_W-1:0]         i_head,
    output logic                     o_found,
    output logic [IDX_W-1:0]         o_idx
);

    // Heap layout: node n has children 2n and 2n+1, leaves start at RS_SIZE.
    always_comb begin : min_tree
        logic             vld [1:2*RS_SIZE-1];
        logic [ROB_W-1:0] age [1:2*RS_SIZE-1];
        logic [IDX_W-1:0] idx [1:2*RS_SIZE-1];
        logic             take_r;
        for (int n = 1; n < 2*RS_SIZE; n++) begin
            vld[n] = 1'b0;
            age[n] = '0;
            idx[n] = '0;
        end
        take_r = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            vld[RS_SIZE+i] = i_ready[i];
            age[RS_SIZE+i] = i_rob[i*ROB_W +: ROB_W] - i_head;
            idx[RS_SIZE+i] = IDX_W'(i);
        end
        for (int n = RS_SIZE-1; n >= 1; n--) begin
            take_r = vld[2*n+1] && (!vld[2*n] || (age[2*n+1] < age[2*n]));
            vld[n] = vld[2*n] || vld[2*n+1];
            age[n] = take_r ? age[2*n+1] : age[2*n];
            idx[n] = take_r ? idx[2*n+1] : idx[2*n];
        end
        o_found = vld[1];
        o_idx   = idx[1];
    end

endmodule

// File: rtl/branch_rs.sv
// Reservation station for control-flow instructions: holds issued branches,
// snoops the ALU/LSB CDBs and dispatches the oldest ready one per cycle.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int RS_SIZE = 4,
    parameter int ROB_W   = ROB_W_DEF,
    parameter int IDX_W   = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic [ROB_W-1:0]     rob_head_in,
    input  logic                 iss_valid,
    input  logic [ORDER_W-1:0]   iss_order,
    input  logic [ROB_W-1:0]     iss_rob,
    input  logic [31:0]          iss_vj,
    input  logic [31:0]          iss_vk,
    input  logic                 iss_qj_rdy,
    input  logic                 iss_qk_rdy,
    input  logic [ROB_W-1:0]     iss_qj,
    input  logic [ROB_W-1:0]     iss_qk,
    input  logic [31:0]          iss_imm,
    input  logic [31:0]          iss_pc,
    output logic                 full,
    input  logic                 alu_cdb_valid,
    input  logic [ROB_W-1:0]     alu_cdb_tag,
    input  logic [CDB_VAL_W-1:0] alu_cdb_val,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_W-1:0]     lsb_cdb_tag,
    input  logic [CDB_VAL_W-1:0] lsb_cdb_val,
    output logic                 ex_valid,
    output logic [ORDER_W-1:0]   ex_order,
    output logic [31:0]          ex_vj,
    output logic [31:0]          ex_vk,
    output logic [31:0]          ex_imm,
    output logic [31:0]          ex_pc,
    output logic [ROB_W-1:0]     ex_rob
);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_rdy;
    logic [RS_SIZE-1:0] r_qk_rdy;
    logic [ORDER_W-1:0] r_order [RS_SIZE];
    logic [ROB_W-1:0]   r_rob   [RS_SIZE];
    logic [ROB_W-1:0]   r_qj    [RS_SIZE];
    logic [ROB_W-1:0]   r_qk    [RS_SIZE];
    logic [31:0]        r_vj    [RS_SIZE];
    logic [31:0]        r_vk    [RS_SIZE];
    logic [31:0]        r_imm   [RS_SIZE];
    logic [31:0]        r_pc    [RS_SIZE];

    logic [RS_SIZE-1:0]       w_cand;
    logic [RS_SIZE*ROB_W-1:0] w_rob_flat;
    logic                     w_found;
    logic [IDX_W-1:0]         w_sel;
    logic [IDX_W-1:0]         w_free_idx;
    logic                     w_iss_ok;
    logic                     w_j_alu, w_j_lsb, w_k_alu, w_k_lsb;
    logic                     w_iss_qj_rdy, w_iss_qk_rdy;
    logic [31:0]              w_iss_vj, w_iss_vk;

    assign full     = &r_busy;
    assign w_iss_ok = iss_valid && !full;

    always_comb begin
        w_free_idx = '0;
        w_rob_flat = '0;
        w_cand     = '0;
        for (int i = RS_SIZE-1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            w_rob_flat[i*ROB_W +: ROB_W] = r_rob[i];
            w_cand[i] = r_busy[i] && r_qj_rdy[i] && r_qk_rdy[i];
        end
    end

    // An operand broadcast in the issue cycle is captured directly, so the
    // entry never waits on a tag that has already gone by.
    assign w_j_alu      = alu_cdb_valid && (alu_cdb_tag == iss_qj);
    assign w_j_lsb      = lsb_cdb_valid && (lsb_cdb_tag == iss_qj);
    assign w_k_alu      = alu_cdb_valid && (alu_cdb_tag == iss_qk);
    assign w_k_lsb      = lsb_cdb_valid && (lsb_cdb_tag == iss_qk);
    assign w_iss_qj_rdy = iss_qj_rdy || w_j_alu || w_j_lsb;
    assign w_iss_qk_rdy = iss_qk_rdy || w_k_alu || w_k_lsb;
    assign w_iss_vj     = iss_qj_rdy ? iss_vj : (w_j_alu ? alu_cdb_val : lsb_cdb_val);
    assign w_iss_vk     = iss_qk_rdy ? iss_vk : (w_k_alu ? alu_cdb_val : lsb_cdb_val);

    branch_rs_select #(
        .RS_SIZE (RS_SIZE),
        .ROB_W   (ROB_W),
        .IDX_W   (IDX_W)
    ) u_select (
        .i_ready (w_cand),
        .i_rob   (w_rob_flat),
        .i_head  (rob_head_in),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy   <= '0;
            r_qj_rdy <= '0;
            r_qk_rdy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_order[i] <= '0;
                r_rob[i]   <= '0;
                r_qj[i]    <= '0;
                r_qk[i]    <= '0;
                r_vj[i]    <= '0;
                r_vk[i]    <= '0;
                r_imm[i]   <= '0;
                r_pc[i]    <= '0;
            end
            ex_valid <= 1'b0;
            ex_order <= '0;
            ex_vj    <= '0;
            ex_vk    <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            ex_rob   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_busy   <= '0;
                ex_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && !r_qj_rdy[i]) begin
                        if (alu_cdb_valid && alu_cdb_tag == r_qj[i]) begin
                            r_vj[i]     <= alu_cdb_val;
                            r_qj_rdy[i] <= 1'b1;
                        end else if (lsb_cdb_valid && lsb_cdb_tag == r_qj[i]) begin
                            r_vj[i]     <= lsb_cdb_val;
                            r_qj_rdy[i] <= 1'b1;
                        end
                    end
                    if (r_busy[i] && !r_qk_rdy[i]) begin
                        if (alu_cdb_valid && alu_cdb_tag == r_qk[i]) begin
                            r_vk[i]     <= alu_cdb_val;
                            r_qk_rdy[i] <= 1'b1;
                        end else if (lsb_cdb_valid && lsb_cdb_tag == r_qk[i]) begin
                            r_vk[i]     <= lsb_cdb_val;
                            r_qk_rdy[i] <= 1'b1;
                        end
                    end
                end
                ex_valid <= w_found;
                if (w_found) begin
                    ex_order      <= r_order[w_sel];
                    ex_vj         <= r_vj[w_sel];
                    ex_vk         <= r_vk[w_sel];
                    ex_imm        <= r_imm[w_sel];
                    ex_pc         <= r_pc[w_sel];
                    ex_rob        <= r_rob[w_sel];
                    r_busy[w_sel] <= 1'b0;
                end
                // The free slot is never the dispatching one, so no conflict.
                if (w_iss_ok) begin
                    r_busy[w_free_idx]   <= 1'b1;
                    r_order[w_free_idx]  <= iss_order;
                    r_rob[w_free_idx]    <= iss_rob;
                    r_qj[w_free_idx]     <= iss_qj;
                    r_qk[w_free_idx]     <= iss_qk;
                    r_qj_rdy[w_free_idx] <= w_iss_qj_rdy;
                    r_qk_rdy[w_free_idx] <= w_iss_qk_rdy;
                    r_vj[w_free_idx]     <= w_iss_vj;
                    r_vk[w_free_idx]     <= w_iss_vk;
                    r_imm[w_free_idx]    <= iss_imm;
                    r_pc[w_free_idx]     <= iss_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: expected dispatches are queued at issue time
// and popped by a monitor whenever ex_valid is seen after a live edge.
module tb_branch_rs;
    import branch_rs_pkg::*;

    localparam int ROB_W = 4;
    localparam int W     = 6 + ROB_W + 32*4;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, flush_in;
    logic [ROB_W-1:0] rob_head_in;
    logic             iss_valid;
    logic [5:0]       iss_order;
    logic [ROB_W-1:0] iss_rob, iss_qj, iss_qk;
    logic [31:0]      iss_vj, iss_vk, iss_imm, iss_pc;
    logic             iss_qj_rdy, iss_qk_rdy;
    logic             full;
    logic             alu_cdb_valid, lsb_cdb_valid;
    logic [ROB_W-1:0] alu_cdb_tag, lsb_cdb_tag;
    logic [31:0]      alu_cdb_val, lsb_cdb_val;
    logic             ex_valid;
    logic [5:0]       ex_order;
    logic [31:0]      ex_vj, ex_vk, ex_imm, ex_pc;
    logic [ROB_W-1:0] ex_rob;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    branch_rs #(.RS_SIZE(4), .ROB_W(ROB_W), .IDX_W(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rob_head_in(rob_head_in),
        .iss_valid(iss_valid), .iss_order(iss_order), .iss_rob(iss_rob),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj_rdy(iss_qj_rdy), .iss_qk_rdy(iss_qk_rdy),
        .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .full(full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_val(lsb_cdb_val),
        .ex_valid(ex_valid), .ex_order(ex_order), .ex_vj(ex_vj), .ex_vk(ex_vk),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rob(ex_rob)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [5:0] o, input logic [ROB_W-1:0] r,
                                          input logic [31:0] vj, input logic [31:0] vk,
                                          input logic [31:0] imm, input logic [31:0] pc);
        return {o, r, vj, vk, imm, pc};
    endfunction

    task automatic drive_issue(input logic [5:0] o, input logic [ROB_W-1:0] r,
                               input logic [31:0] vj, input logic [31:0] vk,
                               input logic jr, input logic [ROB_W-1:0] qj,
                               input logic kr, input logic [ROB_W-1:0] qk,
                               input logic [31:0] imm, input logic [31:0] pc);
        iss_valid  = 1'b1;
        iss_order  = o;
        iss_rob    = r;
        iss_vj     = vj;
        iss_vk     = vk;
        iss_qj_rdy = jr;
        iss_qj     = qj;
        iss_qk_rdy = kr;
        iss_qk     = qk;
        iss_imm    = imm;
        iss_pc     = pc;
    endtask

    task automatic alu_bcast(input logic [ROB_W-1:0] t, input logic [31:0] v);
        alu_cdb_valid = 1'b1;
        alu_cdb_tag   = t;
        alu_cdb_val   = v;
    endtask

    task automatic lsb_bcast(input logic [ROB_W-1:0] t, input logic [31:0] v);
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = t;
        lsb_cdb_val   = v;
    endtask

    // One clock: step to the next falling edge, then drop one-shot strobes.
    task automatic tick();
        @(negedge clk_in);
        iss_valid     = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
        flush_in      = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic         live;
        logic [W-1:0] got;
        forever begin
            @(posedge clk_in);
            live = rdy_in && !rst_in;
            #2;
            if (live && ex_valid) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_dispatch observed rob=%0d expected none", ex_rob);
                end
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("dispatch", pack(ex_order, ex_rob, ex_vj, ex_vk, ex_imm, ex_pc), got);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; rob_head_in = '0;
        iss_valid = 1'b0; iss_order = '0; iss_rob = '0; iss_vj = '0; iss_vk = '0;
        iss_qj_rdy = 1'b0; iss_qk_rdy = 1'b0; iss_qj = '0; iss_qk = '0;
        iss_imm = '0; iss_pc = '0;
        alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_val = '0;
        lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_val = '0;
        #1;
        check("rst_full", W'(full), W'(0));
        check("rst_ex_valid", W'(ex_valid), W'(0));
        check("rst_ex_fields", pack(ex_order, ex_rob, ex_vj, ex_vk, ex_imm, ex_pc), '0);
        tick(); tick();
        rst_in = 1'b0;

        // Ready BEQ dispatches one cycle after issue.
        drive_issue(ORD_BEQ, 4'd5, 32'd7, 32'd7, 1'b1, 4'd0, 1'b1, 4'd0, 32'd16, 32'h100);
        exp_q.push_back(pack(ORD_BEQ, 4'd5, 32'd7, 32'd7, 32'd16, 32'h100));
        tick();
        check("beq_not_yet", W'(ex_valid), W'(0));
        tick();
        check("beq_valid", W'(ex_valid), W'(1));
        check("beq_order", W'(ex_order), W'(31));
        check("beq_rob", W'(ex_rob), W'(5));
        check("beq_vj_vk", W'({ex_vj, ex_vk}), W'({32'd7, 32'd7}));
        tick();
        check("beq_drop", W'(ex_valid), W'(0));

        // BLT waits on tag 3, woken by ALU.
        drive_issue(ORD_BLT, 4'd6, 32'd0, 32'd9, 1'b0, 4'd3, 1'b1, 4'd0, 32'd8, 32'h200);
        tick(); tick();
        check("blt_waiting", W'(ex_valid), W'(0));
        alu_bcast(4'd3, 32'hFFFF_FFF0);
        exp_q.push_back(pack(ORD_BLT, 4'd6, 32'hFFFF_FFF0, 32'd9, 32'd8, 32'h200));
        tick();
        check("blt_wake_edge", W'(ex_valid), W'(0));
        tick();
        check("blt_dispatch", W'(ex_valid), W'(1));
        check("blt_vj", W'(ex_vj), W'(32'hFFFF_FFF0));

        // Same-cycle LSB capture at issue.
        drive_issue(ORD_BLT, 4'd7, 32'd0, 32'd9, 1'b0, 4'd3, 1'b1, 4'd0, 32'd4, 32'h300);
        lsb_bcast(4'd3, 32'h1234);
        exp_q.push_back(pack(ORD_BLT, 4'd7, 32'h1234, 32'd9, 32'd4, 32'h300));
        tick(); tick();
        check("cap_dispatch", W'({ex_valid, ex_rob}), W'({1'b1, 4'd7}));
        check("cap_vj", W'(ex_vj), W'(32'h1234));

        // Age order across the tag wrap: head 14 -> 15, 0, 1.
        rob_head_in = 4'd14;
        drive_issue(ORD_BNE, 4'd1, 32'd0, 32'd11, 1'b0, 4'd9, 1'b1, 4'd0, 32'd1, 32'h400);
        tick();
        drive_issue(ORD_BGE, 4'd15, 32'd0, 32'd12, 1'b0, 4'd9, 1'b1, 4'd0, 32'd2, 32'h404);
        tick();
        drive_issue(ORD_BGEU, 4'd0, 32'd0, 32'd13, 1'b0, 4'd9, 1'b1, 4'd0, 32'd3, 32'h408);
        tick();
        alu_bcast(4'd9, 32'h55);
        exp_q.push_back(pack(ORD_BGE, 4'd15, 32'h55, 32'd12, 32'd2, 32'h404));
        exp_q.push_back(pack(ORD_BGEU, 4'd0, 32'h55, 32'd13, 32'd3, 32'h408));
        exp_q.push_back(pack(ORD_BNE, 4'd1, 32'h55, 32'd11, 32'd1, 32'h400));
        tick(); tick();
        check("wrap_first", W'(ex_rob), W'(15));
        tick();
        check("wrap_second", W'(ex_rob), W'(0));
        tick();
        check("wrap_third", W'(ex_rob), W'(1));
        tick();
        check("wrap_idle", W'(ex_valid), W'(0));

        // Fill, ignored issue at full, dispatch frees a slot a cycle later.
        rob_head_in = 4'd0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(ORD_BLTU, 4'(i + 1), 32'd0, 32'd20, 1'b0, 4'(i + 10), 1'b1, 4'd0, 32'd0, 32'h500);
            tick();
        end
        check("full_set", W'(full), W'(1));
        drive_issue(ORD_BEQ, 4'd5, 32'd1, 32'd1, 1'b1, 4'd0, 1'b1, 4'd0, 32'd0, 32'h600);
        tick();
        check("full_ignore", W'(full), W'(1));
        alu_bcast(4'd10, 32'hA);
        exp_q.push_back(pack(ORD_BLTU, 4'd1, 32'hA, 32'd20, 32'd0, 32'h500));
        tick();
        check("full_wake_edge", W'(full), W'(1));
        drive_issue(ORD_BEQ, 4'd6, 32'd1, 32'd1, 1'b1, 4'd0, 1'b1, 4'd0, 32'd0, 32'h700);
        tick();
        check("full_dispatch", W'({ex_valid, ex_rob}), W'({1'b1, 4'd1}));
        check("full_cleared", W'(full), W'(0));

        // Asynchronous reset between edges with three busy entries.
        #1 rst_in = 1'b1;
        #1;
        check("mid_rst_ex_valid", W'(ex_valid), W'(0));
        check("mid_rst_full", W'(full), W'(0));
        rst_in = 1'b0;
        tick();
        lsb_bcast(4'd11, 32'h0);
        alu_bcast(4'd12, 32'h0);
        tick();
        lsb_bcast(4'd13, 32'h0);
        tick();

        // Flush with two busy entries and a same-cycle issue.
        drive_issue(ORD_BNE, 4'd1, 32'd0, 32'd1, 1'b0, 4'd8, 1'b1, 4'd0, 32'd0, 32'h800);
        tick();
        drive_issue(ORD_BNE, 4'd2, 32'd0, 32'd1, 1'b0, 4'd8, 1'b1, 4'd0, 32'd0, 32'h804);
        tick();
        drive_issue(ORD_BEQ, 4'd3, 32'd1, 32'd1, 1'b1, 4'd0, 1'b1, 4'd0, 32'd0, 32'h808);
        flush_in = 1'b1;
        tick();
        check("flush_full", W'(full), W'(0));
        alu_bcast(4'd8, 32'h77);
        tick(); tick(); tick();
        check("flush_no_dispatch", W'(ex_valid), W'(0));
        for (int i = 0; i < 4; i++) begin
            drive_issue(ORD_BGE, 4'(i + 4), 32'd0, 32'd0, 1'b0, 4'd15, 1'b1, 4'd0, 32'd0, 32'h900);
            tick();
            check("refill_full", W'(full), W'(i == 3));
        end
        flush_in = 1'b1;
        tick();

        // Freeze holds ex_valid and fields; dispatch resumes on first live edge.
        drive_issue(ORD_JAL, 4'd1, 32'd0, 32'd0, 1'b1, 4'd0, 1'b1, 4'd0, 32'd40, 32'hA00);
        exp_q.push_back(pack(ORD_JAL, 4'd1, 32'd0, 32'd0, 32'd40, 32'hA00));
        tick();
        drive_issue(ORD_JALR, 4'd2, 32'h44, 32'd0, 1'b1, 4'd0, 1'b1, 4'd0, 32'd4, 32'hA04);
        exp_q.push_back(pack(ORD_JALR, 4'd2, 32'h44, 32'd0, 32'd4, 32'hA04));
        tick();
        check("pre_freeze", W'({ex_valid, ex_rob}), W'({1'b1, 4'd1}));
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_hold", W'({ex_valid, ex_rob}), W'({1'b1, 4'd1}));
        end
        rdy_in = 1'b1;
        tick();
        check("thaw_dispatch", W'({ex_valid, ex_rob}), W'({1'b1, 4'd2}));
        tick();
        check("thaw_idle", W'(ex_valid), W'(0));

        repeat (3) tick();
        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
